column_readout_arbiter: RTL

//  Round-robin arbiter that shares one column readout bus among N_SP super pixels.

---
 rtl/column_readout_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/column_readout_arbiter.sv
// Round-robin arbiter that shares one column readout bus among N_SP super pixels.
// Optional transfer counter enabled by defining HIT_COUNTER_EN.
module column_readout_arbiter #(
  parameter int N_SP   = 8,
  parameter int DATA_W = 26,
  parameter int IDX_W  = 3,
  parameter int COL_W  = 6
) (
  input  logic                            clk_40MHz,
  input  logic                            rst,
  input  logic                            readout_en,
  input  logic [COL_W-1:0]                col_addr,
  input  logic [N_SP-1:0]                 sp_req,
  input  logic [N_SP*DATA_W-1:0]          sp_data,
  output logic [N_SP-1:0]                 sp_ack,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COL_W+IDX_W+DATA_W-1:0]   out_data,
  output logic                            busy,
  output logic [15:0]                     hit_count
);

  typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  int               cand;

  // Rotating-priority search: ptr+1 has highest priority, ptr itself lowest.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 1; i <= N_SP; i++) begin
      cand = (int'(ptr) + i) % N_SP;
      if (!grant_found && sp_req[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // ptr doubles as the index of the word in flight between grant and ACK.
  always_ff @(posedge clk_40MHz) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      sp_ack    <= '0;
      busy      <= 1'b0;
      ptr       <= IDX_W'(N_SP - 1);
    end else begin
      case (state)
        IDLE: begin
          if (readout_en && grant_found) begin
            out_data  <= {col_addr, grant_idx, sp_data[int'(grant_idx)*DATA_W +: DATA_W]};
            out_valid <= 1'b1;
            busy      <= 1'b1;
            ptr       <= grant_idx;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sp_ack    <= N_SP'(1) << ptr;
            state     <= ACK;
          end
        end
        ACK: begin
          sp_ack <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          sp_ack    <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef HIT_COUNTER_EN
  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      hit_count <= '0;
    end else if (out_valid && out_ready && hit_count != 16'hFFFF) begin
      hit_count <= hit_count + 16'd1;
    end
  end
`else
  assign hit_count = 16'h0000;
`endif

endmodule
